vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; next generation of the fixed 640x480 controller used by the display top. It runs on the system clock with an internal pixel-enable strobe instead of a divided clock, and supports configurable resolution, porches, sync polarity and clock ratio. It also emits frame/line strobes and a frame counter. It sits between the clock source and text/pixel renderers, which consume h_cnt/v_cnt/valid.

---
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel/text renderers.
// The master drives coordinates, syncs and strobes; renderers attach as slaves.
interface vga_timing_gen_if #(
   parameter int CNT_W = 10,
   parameter int FRM_W = 8
);
   logic             pix_en;
   logic             hsync;
   logic             vsync;
   logic             valid;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             line_start;
   logic             frame_start;
   logic [FRM_W-1:0] frame_cnt;

   modport master (
      output pix_en, hsync, vsync, valid, h_cnt, v_cnt,
             line_start, frame_start, frame_cnt
   );

   modport slave (
      input  pix_en, hsync, vsync, valid, h_cnt, v_cnt,
             line_start, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator driven by a pixel-enable strobe.
// Optional macro VGA_BORDER_BLANK_EN adds parameter BORDER that blanks a frame around the active area.
module vga_timing_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
`ifdef VGA_BORDER_BLANK_EN
   parameter int BORDER   = 0,
`endif
   parameter int CNT_W    = 10,
   parameter int FRM_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   vga_timing_gen_if.master   vga_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic             SYNC_ACT = 1'(SYNC_POL);

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_en_q, pix_en_d;
   logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
   logic [CNT_W-1:0] h_cnt_q, v_cnt_q;
   logic             valid_q, valid_d;
   logic             hsync_q, hsync_d, vsync_q, vsync_d;
   logic             line_start_q, line_start_d;
   logic             frame_start_q, frame_start_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             seen_frm_q, seen_frm_d;

   // Window compares run at 32 bits so a sync end equal to 2**CNT_W cannot alias to 0.
   logic [31:0] hc_w, vc_w;
   assign hc_w = 32'(hc_q);
   assign vc_w = 32'(vc_q);

   always_comb begin
      div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      pix_en_d      = (div_d == DIV_LAST);
      hc_d          = hc_q;
      vc_d          = vc_q;
      valid_d       = valid_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      seen_frm_d    = seen_frm_q;
      if (pix_en_q) begin
         if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
         end else begin
            hc_d = hc_q + 1'b1;
         end
         valid_d = (hc_w < 32'(H_ACTIVE)) && (vc_w < 32'(V_ACTIVE));
`ifdef VGA_BORDER_BLANK_EN
         valid_d = valid_d && (hc_w >= 32'(BORDER)) && (hc_w < 32'(H_ACTIVE - BORDER))
                           && (vc_w >= 32'(BORDER)) && (vc_w < 32'(V_ACTIVE - BORDER));
`endif
         hsync_d = ((hc_w >= 32'(H_ACTIVE + H_FP)) && (hc_w < 32'(H_ACTIVE + H_FP + H_SYNC)))
                   ? SYNC_ACT : ~SYNC_ACT;
         vsync_d = ((vc_w >= 32'(V_ACTIVE + V_FP)) && (vc_w < 32'(V_ACTIVE + V_FP + V_SYNC)))
                   ? SYNC_ACT : ~SYNC_ACT;
         line_start_d  = (hc_q == '0);
         frame_start_d = (hc_q == '0) && (vc_q == '0);
         // The frame presented right after reset is frame 0, so it does not count.
         if (frame_start_d) begin
            seen_frm_d = 1'b1;
            if (seen_frm_q) frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         pix_en_q      <= 1'b0;
         hc_q          <= '0;
         vc_q          <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         valid_q       <= 1'b0;
         hsync_q       <= ~SYNC_ACT;
         vsync_q       <= ~SYNC_ACT;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
         seen_frm_q    <= 1'b0;
      end else begin
         div_q         <= div_d;
         pix_en_q      <= pix_en_d;
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         if (pix_en_q) begin
            h_cnt_q <= hc_q;
            v_cnt_q <= vc_q;
         end
         valid_q       <= valid_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
         seen_frm_q    <= seen_frm_d;
      end
   end

   assign vga_o.pix_en      = pix_en_q;
   assign vga_o.hsync       = hsync_q;
   assign vga_o.vsync       = vsync_q;
   assign vga_o.valid       = valid_q;
   assign vga_o.h_cnt       = h_cnt_q;
   assign vga_o.v_cnt       = v_cnt_q;
   assign vga_o.line_start  = line_start_q;
   assign vga_o.frame_start = frame_start_q;
   assign vga_o.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a tiny CLK_DIV=1 raster
// in both sync polarities, asynchronous reset, and the border-blank build when enabled.
module tb_vga_timing_gen;
   logic clk;
   logic rst_d, rst_s;
   int   n_chk, n_fail;

   vga_timing_gen_if #(.CNT_W(10), .FRM_W(8)) vd ();
   vga_timing_gen_if #(.CNT_W(4),  .FRM_W(2)) vs ();
   vga_timing_gen_if #(.CNT_W(4),  .FRM_W(2)) vp ();

   vga_timing_gen dut_d (.clk(clk), .rst(rst_d), .vga_o(vd));

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0),
      .CNT_W(4), .FRM_W(2)
   ) dut_s (.clk(clk), .rst(rst_s), .vga_o(vs));

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1),
      .CNT_W(4), .FRM_W(2)
   ) dut_p (.clk(clk), .rst(rst_s), .vga_o(vp));

`ifdef VGA_BORDER_BLANK_EN
   logic rst_b;
   vga_timing_gen_if #(.CNT_W(10), .FRM_W(8)) vb ();
   vga_timing_gen #(.CLK_DIV(1), .BORDER(8)) dut_b (.clk(clk), .rst(rst_b), .vga_o(vb));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_d = 1'b1;
      rst_s = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (vd.pix_en !== 1'b0) begin n_fail++; $display("FAIL rst_pix_en: got %b want 0", vd.pix_en); end
      n_chk++; if (vd.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", vd.valid); end
      n_chk++; if (vd.h_cnt !== 10'd0) begin n_fail++; $display("FAIL rst_h_cnt: got %0d want 0", vd.h_cnt); end
      n_chk++; if (vd.v_cnt !== 10'd0) begin n_fail++; $display("FAIL rst_v_cnt: got %0d want 0", vd.v_cnt); end
      n_chk++; if (vd.hsync !== 1'b1 || vd.vsync !== 1'b1) begin n_fail++; $display("FAIL rst_syncs: got %b%b want 11", vd.hsync, vd.vsync); end
      n_chk++; if (vd.line_start !== 1'b0 || vd.frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: got %b%b want 00", vd.line_start, vd.frame_start); end
      n_chk++; if (vd.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d want 0", vd.frame_cnt); end
      n_chk++; if (vs.hsync !== 1'b1 || vs.vsync !== 1'b1) begin n_fail++; $display("FAIL rst_syncs_low_pol: got %b%b want 11", vs.hsync, vs.vsync); end
      n_chk++; if (vp.hsync !== 1'b0 || vp.vsync !== 1'b0) begin n_fail++; $display("FAIL rst_syncs_high_pol: got %b%b want 00", vp.hsync, vp.vsync); end
   endtask

   // Release at a falling edge; pix_en is high after posedge 3, 7, 11 and pixel (0,0) shows after posedge 4.
   task automatic test_pix_en();
      @(negedge clk);
      rst_d = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         n_chk++; if (vd.pix_en !== ((k % 4) == 3)) begin n_fail++; $display("FAIL pix_en_k%0d: got %b want %b", k, vd.pix_en, ((k % 4) == 3)); end
         n_chk++; if (vd.frame_start !== (k == 4)) begin n_fail++; $display("FAIL frame_start_k%0d: got %b want %b", k, vd.frame_start, (k == 4)); end
         n_chk++; if (vd.line_start !== (k == 4)) begin n_fail++; $display("FAIL line_start_k%0d: got %b want %b", k, vd.line_start, (k == 4)); end
         n_chk++; if (vd.valid !== (k >= 4)) begin n_fail++; $display("FAIL valid_k%0d: got %b want %b", k, vd.valid, (k >= 4)); end
         if (k == 4) begin
            n_chk++; if (vd.h_cnt !== 10'd0 || vd.v_cnt !== 10'd0) begin n_fail++; $display("FAIL first_xy: got %0d,%0d want 0,0", vd.h_cnt, vd.v_cnt); end
            n_chk++; if (vd.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL first_frame_cnt: got %0d want 0", vd.frame_cnt); end
         end
      end
      n_chk++; if (vd.h_cnt !== 10'd2) begin n_fail++; $display("FAIL h_cnt_after_12: got %0d want 2", vd.h_cnt); end
   endtask

   // Scan the rest of line 0 (pixels 2..799); one pix_en sample per displayed pixel.
   task automatic test_hsync_line();
      int hs_ticks, vld_ticks, h_beg, h_end;
      bit done;
      hs_ticks = 0; vld_ticks = 0; h_beg = -1; h_end = -1; done = 0;
      for (int c = 0; c < 3400 && !done; c++) begin
         @(posedge clk);
         #1;
         if (vd.v_cnt != 10'd0) begin
            done = 1;
         end else begin
            if (vd.hsync == 1'b0 && h_beg < 0) h_beg = int'(vd.h_cnt);
            if (vd.hsync == 1'b1 && h_beg >= 0 && h_end < 0) h_end = int'(vd.h_cnt);
            if (vd.pix_en && vd.hsync == 1'b0) hs_ticks++;
            if (vd.pix_en && vd.valid) vld_ticks++;
         end
      end
      n_chk++; if (!done) begin n_fail++; $display("FAIL line_timeout: got no v_cnt=1 want line end within 3400 clks"); end
      n_chk++; if (h_beg != 656) begin n_fail++; $display("FAIL hsync_start: got %0d want 656", h_beg); end
      n_chk++; if (h_end != 752) begin n_fail++; $display("FAIL hsync_end: got %0d want 752", h_end); end
      n_chk++; if (hs_ticks != 96) begin n_fail++; $display("FAIL hsync_ticks: got %0d want 96", hs_ticks); end
      n_chk++; if (vld_ticks != 638) begin n_fail++; $display("FAIL valid_ticks: got %0d want 638", vld_ticks); end
      n_chk++; if (vd.h_cnt !== 10'd0 || vd.v_cnt !== 10'd1) begin n_fail++; $display("FAIL line1_xy: got %0d,%0d want 0,1", vd.h_cnt, vd.v_cnt); end
      n_chk++; if (vd.line_start !== 1'b1 || vd.frame_start !== 1'b0) begin n_fail++; $display("FAIL line1_strobes: got %b%b want 10", vd.line_start, vd.frame_start); end
   endtask

   task automatic test_reset_mid_line();
      bit hit;
      hit = 0;
      for (int c = 0; c < 4000 && !hit; c++) begin
         @(posedge clk);
         #1;
         if (vd.h_cnt == 10'd300) hit = 1;
      end
      n_chk++; if (!hit) begin n_fail++; $display("FAIL mid_timeout: got no h_cnt=300 want it within 4000 clks"); end
      #2 rst_d = 1'b1;
      #1;
      n_chk++; if (vd.h_cnt !== 10'd0 || vd.v_cnt !== 10'd0) begin n_fail++; $display("FAIL mid_rst_xy: got %0d,%0d want 0,0", vd.h_cnt, vd.v_cnt); end
      n_chk++; if (vd.valid !== 1'b0 || vd.pix_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid_pix: got %b%b want 00", vd.valid, vd.pix_en); end
      n_chk++; if (vd.hsync !== 1'b1 || vd.vsync !== 1'b1) begin n_fail++; $display("FAIL mid_rst_syncs: got %b%b want 11", vd.hsync, vd.vsync); end
      @(negedge clk);
      rst_d = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_chk++; if (vd.h_cnt !== 10'd0 || vd.v_cnt !== 10'd0 || vd.valid !== 1'b1) begin n_fail++; $display("FAIL restart_xy: got %0d,%0d,%b want 0,0,1", vd.h_cnt, vd.v_cnt, vd.valid); end
      n_chk++; if (vd.frame_start !== 1'b1 || vd.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL restart_frame: got %b,%0d want 1,0", vd.frame_start, vd.frame_cnt); end
   endtask

   // 12x7 raster at one pixel per clk: pixel p shows after posedge p+2; frame = 84 clks.
   task automatic test_small_frames();
      int p, h, v, f;
      bit ehs, evs;
      @(negedge clk);
      rst_s = 1'b0;
      @(posedge clk);
      #1;
      n_chk++; if (vs.pix_en !== 1'b1 || vs.valid !== 1'b0) begin n_fail++; $display("FAIL small_k1: got pix_en %b valid %b want 1 0", vs.pix_en, vs.valid); end
      for (int k = 2; k <= 2 + 84 * 5 + 4; k++) begin
         @(posedge clk);
         #1;
         p = k - 2; h = p % 12; v = (p / 12) % 7; f = p / 84;
         ehs = (h >= 9) && (h < 11);
         evs = (v == 5);
         n_chk++; if (int'(vs.h_cnt) != h || int'(vs.v_cnt) != v) begin n_fail++; $display("FAIL small_xy_p%0d: got %0d,%0d want %0d,%0d", p, vs.h_cnt, vs.v_cnt, h, v); end
         n_chk++; if (vs.valid !== ((h < 8) && (v < 4))) begin n_fail++; $display("FAIL small_valid_p%0d: got %b want %b", p, vs.valid, ((h < 8) && (v < 4))); end
         n_chk++; if (vs.hsync !== !ehs || vs.vsync !== !evs) begin n_fail++; $display("FAIL small_sync_low_p%0d: got %b%b want %b%b", p, vs.hsync, vs.vsync, !ehs, !evs); end
         n_chk++; if (vp.hsync !== ehs || vp.vsync !== evs) begin n_fail++; $display("FAIL small_sync_high_p%0d: got %b%b want %b%b", p, vp.hsync, vp.vsync, ehs, evs); end
         n_chk++; if (vs.line_start !== (h == 0) || vs.frame_start !== (p % 84 == 0)) begin n_fail++; $display("FAIL small_strobes_p%0d: got %b%b want %b%b", p, vs.line_start, vs.frame_start, (h == 0), (p % 84 == 0)); end
         n_chk++; if (int'(vs.frame_cnt) != (f % 4)) begin n_fail++; $display("FAIL small_frame_cnt_p%0d: got %0d want %0d", p, vs.frame_cnt, f % 4); end
      end
   endtask

   task automatic test_small_reset();
      bit hit;
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(posedge clk);
         #1;
         if (vs.v_cnt == 4'd3 && vs.h_cnt == 4'd5) hit = 1;
      end
      n_chk++; if (!hit) begin n_fail++; $display("FAIL small_mid_timeout: got no (5,3) want it within 200 clks"); end
      n_chk++; if (vs.frame_cnt !== 2'd1) begin n_fail++; $display("FAIL small_pre_rst_frame_cnt: got %0d want 1", vs.frame_cnt); end
      #2 rst_s = 1'b1;
      #1;
      n_chk++; if (vs.frame_cnt !== 2'd0 || vs.h_cnt !== 4'd0 || vs.v_cnt !== 4'd0) begin n_fail++; $display("FAIL small_rst_state: got fc %0d xy %0d,%0d want 0 0,0", vs.frame_cnt, vs.h_cnt, vs.v_cnt); end
      n_chk++; if (vs.pix_en !== 1'b0 || vs.valid !== 1'b0 || vp.hsync !== 1'b0 || vs.hsync !== 1'b1) begin n_fail++; $display("FAIL small_rst_outs: got pe %b v %b hsH %b hsL %b want 0 0 0 1", vs.pix_en, vs.valid, vp.hsync, vs.hsync); end
      @(negedge clk);
      rst_s = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (vs.frame_start !== 1'b1 || vs.frame_cnt !== 2'd0 || vs.h_cnt !== 4'd0) begin n_fail++; $display("FAIL small_restart: got fs %b fc %0d h %0d want 1 0 0", vs.frame_start, vs.frame_cnt, vs.h_cnt); end
      repeat (84) @(posedge clk);
      #1;
      n_chk++; if (vs.frame_start !== 1'b1 || vs.frame_cnt !== 2'd1) begin n_fail++; $display("FAIL small_second_frame: got fs %b fc %0d want 1 1", vs.frame_start, vs.frame_cnt); end
   endtask

`ifdef VGA_BORDER_BLANK_EN
   task automatic test_border();
      int p, h, v;
      bit ev, ehs;
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      @(posedge clk);
      for (int k = 2; k <= 2 + 9 * 800; k++) begin
         @(posedge clk);
         #1;
         p = k - 2; h = p % 800; v = p / 800;
         ev  = (h >= 8) && (h < 632) && (v >= 8) && (v < 472);
         ehs = (h >= 656) && (h < 752);
         n_chk++; if (vb.valid !== ev) begin n_fail++; $display("FAIL border_valid_%0d_%0d: got %b want %b", h, v, vb.valid, ev); end
         n_chk++; if (vb.hsync !== !ehs) begin n_fail++; $display("FAIL border_hsync_%0d_%0d: got %b want %b", h, v, vb.hsync, !ehs); end
      end
   endtask
`endif

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_d = 1'b1;
      rst_s = 1'b1;
`ifdef VGA_BORDER_BLANK_EN
      rst_b = 1'b1;
`endif
      test_reset();
      test_pix_en();
      test_hsync_line();
      test_reset_mid_line();
      test_small_frames();
      test_small_reset();
`ifdef VGA_BORDER_BLANK_EN
      test_border();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
